// File: rtl/shift_leds_pkg.sv
// Shared constants for the LED sequencer: prescaler limits, switch bit map, reset pattern.
// SHIFT_LEDS_FAST_SIM_EN shrinks the prescaler limits so rotations are short in simulation.
package shift_leds_pkg;

  localparam int C_N_LEDS   = 4;
  localparam int C_NB_SEL   = 2;
  localparam int C_NB_COUNT = 14;
  localparam int C_NB_SW    = 4;

  localparam int SW_EN      = 0;
  localparam int SW_SEL_LSB = 1;
  localparam int SW_COLOR   = 3;

`ifdef SHIFT_LEDS_FAST_SIM_EN
  localparam int unsigned R0 = 3;
  localparam int unsigned R1 = 7;
  localparam int unsigned R2 = 15;
  localparam int unsigned R3 = 31;
`else
  localparam int unsigned R0 = (1 << (C_NB_COUNT - 3)) - 1;
  localparam int unsigned R1 = (1 << (C_NB_COUNT - 2)) - 1;
  localparam int unsigned R2 = (1 << (C_NB_COUNT - 1)) - 1;
  localparam int unsigned R3 = (1 << C_NB_COUNT) - 1;
`endif

  localparam logic [C_N_LEDS-1:0] LED_RESET = 4'b0001;

  function automatic int unsigned limit_sel(input logic [1:0] sel);
    int unsigned lim;
    case (sel)
      2'd0:    lim = R0;
      2'd1:    lim = R1;
      2'd2:    lim = R2;
      default: lim = R3;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/shift_leds_prescaler.sv
// Free-running prescaler: counts up to a switch-selected limit, wraps to zero and pulses a tick.
module shift_leds_prescaler
  import shift_leds_pkg::*;
#(
  parameter int NB_SEL   = C_NB_SEL,
  parameter int NB_COUNT = C_NB_COUNT
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [NB_SEL-1:0] i_sel,
  output logic              o_tick
);

  logic [NB_COUNT-1:0] r_count;
  logic [NB_COUNT-1:0] w_limit;
  logic                w_wrap;

  assign w_limit = NB_COUNT'(limit_sel(2'(i_sel)));
  // >= rather than == so a limit lowered below the current count wraps at once
  assign w_wrap  = (r_count >= w_limit);
  assign o_tick  = i_en & w_wrap;

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_wrap ? '0 : r_count + NB_COUNT'(1);
    end
  end

endmodule

// File: rtl/shift_leds.sv
// LED sequencer top: prescaler tick rotates a one-hot LED pattern, gated onto blue or green.
// Build option: SHIFT_LEDS_FAST_SIM_EN (short prescaler limits, see shift_leds_pkg).
module shift_leds
  import shift_leds_pkg::*;
#(
  parameter int N_LEDS   = C_N_LEDS,
  parameter int NB_SEL   = C_NB_SEL,
  parameter int NB_COUNT = C_NB_COUNT,
  parameter int NB_SW    = C_NB_SW
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic [NB_SW-1:0]  i_sw,
  output logic [N_LEDS-1:0] o_led,
  output logic [N_LEDS-1:0] o_led_b,
  output logic [N_LEDS-1:0] o_led_g
);

  localparam logic [N_LEDS-1:0] LP_LED_RESET = N_LEDS'(LED_RESET);

  logic              w_tick;
  logic              w_color;
  logic [N_LEDS-1:0] r_led;

  shift_leds_prescaler #(
    .NB_SEL   (NB_SEL),
    .NB_COUNT (NB_COUNT)
  ) u_prescaler (
    .clock   (clock),
    .i_reset (i_reset),
    .i_en    (i_sw[SW_EN]),
    .i_sel   (i_sw[SW_SEL_LSB +: NB_SEL]),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_led <= LP_LED_RESET;
    end else if (w_tick) begin
      r_led <= {r_led[N_LEDS-2:0], r_led[N_LEDS-1]};
    end
  end

  // Colour gating is combinational so it tracks the switch even during reset
  assign w_color = i_sw[SW_COLOR];
  assign o_led   = r_led;
  assign o_led_b = w_color ? r_led : '0;
  assign o_led_g = w_color ? '0 : r_led;

endmodule

// File: tb/tb_shift_leds.sv
// Directed self-checking bench for shift_leds; limits follow SHIFT_LEDS_FAST_SIM_EN like the RTL.
module tb_shift_leds;

`ifdef SHIFT_LEDS_FAST_SIM_EN
  localparam int L0 = 3;
  localparam int L3 = 31;
`else
  localparam int L0 = 2047;
  localparam int L3 = 16383;
`endif

  logic       clock;
  logic       i_reset;
  logic [3:0] i_sw;
  logic [3:0] o_led;
  logic [3:0] o_led_b;
  logic [3:0] o_led_g;

  int n_cmp = 0;
  int n_err = 0;

  shift_leds dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_sw    (i_sw),
    .o_led   (o_led),
    .o_led_b (o_led_b),
    .o_led_g (o_led_g)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // n rising edges, then park on the following falling edge
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    i_reset = 1'b1;
    i_sw    = 4'b0000;
    #23;
    check("rst_led", o_led,   4'b0001);
    check("rst_b",   o_led_b, 4'b0000);
    check("rst_g",   o_led_g, 4'b0001);

    @(negedge clock);
    i_reset = 1'b0;
    step(40);
    check("idle_led", o_led,   4'b0001);
    check("idle_g",   o_led_g, 4'b0001);

    // run at R0 from a fresh reset
    i_reset = 1'b1;
    i_sw    = 4'b0001;
    step(2);
    i_reset = 1'b0;
    step(L0);
    check("r0_pre1",  o_led, 4'b0001);
    step(1);
    check("r0_rot1",  o_led, 4'b0010);
    check("r0_rot1g", o_led_g, 4'b0010);
    step(L0);
    check("r0_pre2",  o_led, 4'b0010);
    step(1);
    check("r0_rot2",  o_led, 4'b0100);
    step(L0 + 1);
    check("r0_rot3",  o_led, 4'b1000);
    step(L0 + 1);
    check("r0_wrap",  o_led, 4'b0001);

    // R3 period, counter just wrapped to 0
    i_sw = 4'b0111;
    step(L3);
    check("r3_pre",   o_led, 4'b0001);
    step(1);
    check("r3_rot",   o_led, 4'b0010);

    // drop to R0 with the count above R0
    step(L0 + 17);
    check("r3_hold",  o_led, 4'b0010);
    i_sw = 4'b0001;
    step(1);
    check("sw_wrap",  o_led, 4'b0100);
    step(L0);
    check("sw_pre",   o_led, 4'b0100);
    step(1);
    check("sw_rot",   o_led, 4'b1000);

    // freeze while 0100 with count = 2
    step(L0 + 1);
    step(L0 + 1);
    step(L0 + 1);
    check("fz_start", o_led, 4'b0100);
    step(2);
    i_sw = 4'b0000;
    step(100);
    check("fz_hold",  o_led, 4'b0100);
    i_sw = 4'b0001;
    step(L0 - 2);
    check("fz_rem",   o_led, 4'b0100);
    step(1);
    check("fz_rot",   o_led, 4'b1000);

    // colour switch visible without a clock edge
    i_sw = 4'b1001;
    #1;
    check("col_b",    o_led_b, 4'b1000);
    check("col_g",    o_led_g, 4'b0000);
    check("col_led",  o_led,   4'b1000);

    // asynchronous reset between edges
    step(1);
    #2;
    i_reset = 1'b1;
    #1;
    check("arst_led", o_led,   4'b0001);
    check("arst_b",   o_led_b, 4'b0001);
    check("arst_g",   o_led_g, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
